// File: rtl/load_store_exec_unit_pkg.sv
// Shared types for the load/store execution unit: FSM states, completion
// exception codes and the alignment helper used when an op is accepted.
package load_store_exec_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } lsu_state_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_BUS      = 2'b10
    } mem_exc_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/load_store_exec_unit_if.sv
// Data-memory request/response bus between the load/store unit (master)
// and the data memory (slave).
interface load_store_exec_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_exec_unit.sv
// Single-lane memory functional unit: one load/store in flight, data-memory
// handshake, and a single-entry completion port toward the PRF and ROB.
module load_store_exec_unit
    import load_store_exec_unit_pkg::*;
#(
    parameter  int NUM_PHYS_REGS  = 64,
    parameter  int ROB_IDX_BITS   = 7,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int PREG_BITS      = $clog2(NUM_PHYS_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    output logic                    mem_available,
    input  logic                    issue_valid,
    input  logic [PREG_BITS-1:0]    issue_prd,
    input  logic [31:0]             issue_addr,
    input  logic [31:0]             issue_data,
    input  logic                    issue_mem_write,
    input  logic                    issue_mem_read,
    input  logic [ROB_IDX_BITS-1:0] issue_rob_idx,
    load_store_exec_unit_if.master  dmem,
    output logic                    cdb_valid,
    output logic [PREG_BITS-1:0]    cdb_prd,
    output logic [31:0]             cdb_data,
    output logic                    cdb_reg_write,
    output logic [ROB_IDX_BITS-1:0] cdb_rob_idx,
    output logic [1:0]              cdb_exc,
    input  logic                    cdb_ready
);

    localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [PREG_BITS-1:0]    prd;
        logic [31:0]             addr;
        logic [31:0]             data;
        logic                    we;
        logic                    rd;
        logic [ROB_IDX_BITS-1:0] rob_idx;
    } lsu_op_t;

    lsu_state_e       state, state_nxt;
    lsu_op_t          op_q;
    mem_exc_e         exc_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             timeout_tc;
    logic             resp_done;

    assign accept     = issue_valid && mem_available;
    // The cycle the counter sits at TIMEOUT_CYCLES-1 is the last allowed WAIT cycle.
    assign timeout_tc = (cnt_q == CNT_TC);
    assign resp_done  = dmem.rvalid || timeout_tc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = is_misaligned(issue_addr) ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (flush)         state_nxt = dmem.gnt ? ST_DRAIN : ST_IDLE;
                else if (dmem.gnt) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving with the flush needs no draining.
                if (flush)          state_nxt = resp_done ? ST_IDLE : ST_DRAIN;
                else if (resp_done) state_nxt = ST_DONE;
            end
            ST_DONE:  if (flush || cdb_ready) state_nxt = ST_IDLE;
            ST_DRAIN: if (resp_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            exc_q   <= EXC_NONE;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state == ST_IDLE && accept) begin
                op_q    <= '{prd: issue_prd, addr: {issue_addr[31:2], 2'b00}, data: issue_data,
                             we: issue_mem_write, rd: issue_mem_read, rob_idx: issue_rob_idx};
                exc_q   <= is_misaligned(issue_addr) ? EXC_MISALIGN : EXC_NONE;
                rdata_q <= '0;
            end
            // rvalid takes priority over a coincident terminal count.
            if (state == ST_WAIT && state_nxt == ST_DONE) begin
                if (dmem.rvalid) begin
                    exc_q   <= EXC_NONE;
                    rdata_q <= (op_q.rd && !op_q.we) ? dmem.rdata : 32'h0;
                end else begin
                    exc_q   <= EXC_BUS;
                end
            end
            if (state == ST_REQ && dmem.gnt)
                cnt_q <= '0;
            else if ((state == ST_WAIT || state == ST_DRAIN) && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_available = 1'b0;
        dmem.req      = 1'b0;
        dmem.we       = 1'b0;
        dmem.addr     = '0;
        dmem.wdata    = '0;
        cdb_valid     = 1'b0;
        cdb_prd       = '0;
        cdb_data      = '0;
        cdb_reg_write = 1'b0;
        cdb_rob_idx   = '0;
        cdb_exc       = '0;
        unique case (state)
            ST_IDLE: mem_available = !flush;
            ST_REQ: begin
                dmem.req   = 1'b1;
                dmem.we    = op_q.we;
                dmem.addr  = op_q.addr;
                dmem.wdata = op_q.data;
            end
            ST_DONE: begin
                cdb_valid     = !flush;
                cdb_prd       = op_q.prd;
                cdb_data      = rdata_q;
                cdb_reg_write = op_q.rd && !op_q.we && (exc_q == EXC_NONE);
                cdb_rob_idx   = op_q.rob_idx;
                cdb_exc       = exc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_exec_unit.sv
// Self-checking bench for load_store_exec_unit: directed corner cases plus
// randomized ops scored against a transaction-level timing/data model.
module tb_load_store_exec_unit;
    import load_store_exec_unit_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst, flush, mem_available, issue_valid;
    logic [5:0]  issue_prd, cdb_prd;
    logic [31:0] issue_addr, issue_data, cdb_data;
    logic        issue_mem_write, issue_mem_read;
    logic [6:0]  issue_rob_idx, cdb_rob_idx;
    logic        cdb_valid, cdb_reg_write, cdb_ready;
    logic [1:0]  cdb_exc;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] mem_model [256];

    load_store_exec_unit_if dmem_bus ();

    load_store_exec_unit #(
        .NUM_PHYS_REGS (64),
        .ROB_IDX_BITS  (7),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .mem_available  (mem_available),
        .issue_valid    (issue_valid),
        .issue_prd      (issue_prd),
        .issue_addr     (issue_addr),
        .issue_data     (issue_data),
        .issue_mem_write(issue_mem_write),
        .issue_mem_read (issue_mem_read),
        .issue_rob_idx  (issue_rob_idx),
        .dmem           (dmem_bus),
        .cdb_valid      (cdb_valid),
        .cdb_prd        (cdb_prd),
        .cdb_data       (cdb_data),
        .cdb_reg_write  (cdb_reg_write),
        .cdb_rob_idx    (cdb_rob_idx),
        .cdb_exc        (cdb_exc),
        .cdb_ready      (cdb_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        issue_valid     = 1'b0;
        flush           = 1'b0;
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = 32'h0;
        cdb_ready       = 1'b0;
    endtask

    task automatic set_issue(input logic [31:0] addr, input logic we);
        issue_prd       = 6'd9;
        issue_addr      = addr;
        issue_data      = 32'hA5A5_0000 ^ addr;
        issue_mem_write = we;
        issue_mem_read  = !we;
        issue_rob_idx   = 7'd17;
    endtask

    task automatic expect_ctl(input string tag, input logic avail, input logic req, input logic cdbv);
        check({tag, ".avail"}, 32'(mem_available), 32'(avail));
        check({tag, ".req"},   32'(dmem_bus.req),  32'(req));
        check({tag, ".cdbv"},  32'(cdb_valid),     32'(cdbv));
    endtask

    // One op with gnt after g REQ cycles, rvalid on WAIT cycle r (none when
    // r >= TIMEOUT), cdb_ready after d DONE cycles. Timing comes from
    // latency = 3 + g + min(r, TIMEOUT-1); misaligned ops complete next cycle.
    task automatic run_op(input logic [5:0] prd, input logic [31:0] addr, input logic [31:0] data,
                          input logic we, input logic [6:0] rob, input int g, input int r,
                          input int d, input bit poke);
        logic        mis, timed_out, exp_rw, req_exp, cdb_exp;
        logic [7:0]  idx;
        logic [1:0]  exp_exc;
        logic [31:0] rsp_word, exp_data;
        int          done;
        idx       = addr[9:2];
        mis       = addr[1:0] != 2'b00;
        timed_out = r >= TIMEOUT;
        if (mis)            begin done = 1;                   exp_exc = 2'b01; end
        else if (timed_out) begin done = 3 + g + TIMEOUT - 1; exp_exc = 2'b10; end
        else                begin done = 3 + g + r;           exp_exc = 2'b00; end
        rsp_word = we ? $urandom : mem_model[idx];
        exp_rw   = !we && exp_exc == 2'b00;
        exp_data = exp_rw ? rsp_word : 32'h0;
        if (we && !mis) mem_model[idx] = data;
        for (int c = 0; c <= done + d + 1; c++) begin
            if (c > 0) next_cycle();
            quiet();
            issue_prd       = prd;
            issue_addr      = addr;
            issue_data      = data;
            issue_mem_write = we;
            issue_mem_read  = !we;
            issue_rob_idx   = rob;
            issue_valid     = (c == 0) || (poke && c >= done && c <= done + d);
            if (poke && c > 0) begin
                issue_addr    = addr ^ 32'h40;
                issue_rob_idx = ~rob;
            end
            if (!mis) begin
                dmem_bus.gnt = (c == 1 + g);
                if (!timed_out && c == 2 + g + r) begin
                    dmem_bus.rvalid = 1'b1;
                    dmem_bus.rdata  = rsp_word;
                end
            end
            cdb_ready = (c == done + d);
            #1;
            req_exp = !mis && c >= 1 && c <= 1 + g;
            cdb_exp = c >= done && c <= done + d;
            check("op.avail", 32'(mem_available), 32'((c == 0) || (c == done + d + 1)));
            check("op.req", 32'(dmem_bus.req), 32'(req_exp));
            check("op.cdbv", 32'(cdb_valid), 32'(cdb_exp));
            if (req_exp) begin
                check("op.addr", dmem_bus.addr, addr);
                check("op.we", 32'(dmem_bus.we), 32'(we));
                if (we) check("op.wdata", dmem_bus.wdata, data);
            end
            if (cdb_exp) begin
                check("op.prd", 32'(cdb_prd), 32'(prd));
                check("op.data", cdb_data, exp_data);
                check("op.regw", 32'(cdb_reg_write), 32'(exp_rw));
                check("op.rob", 32'(cdb_rob_idx), 32'(rob));
                check("op.exc", 32'(cdb_exc), 32'(exp_exc));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
        mem_model[8'h40] = 32'hDEAD_BEEF;
        quiet();
        set_issue(32'h0, 1'b0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        expect_ctl("reset", 1'b1, 1'b0, 1'b0);
        check("reset.addr", dmem_bus.addr, 32'h0);
        check("reset.exc", 32'(cdb_exc), 32'h0);
        rst = 1'b0;
        next_cycle();

        // Minimum-latency load, long-stalled store, misaligned load.
        run_op(6'd5, 32'h100, 32'h0, 1'b0, 7'd3, 0, 0, 0, 1'b0);
        run_op(6'd6, 32'h204, 32'h1234_5678, 1'b1, 7'd4, 5, 1, 0, 1'b0);
        run_op(6'd7, 32'h102, 32'h0, 1'b0, 7'd5, 0, 0, 0, 1'b0);
        // Timeout, and rvalid coinciding with terminal count.
        run_op(6'd8, 32'h108, 32'h0, 1'b0, 7'd6, 1, TIMEOUT, 0, 1'b0);
        run_op(6'd9, 32'h10C, 32'h0, 1'b0, 7'd7, 0, TIMEOUT - 1, 0, 1'b0);
        // CDB back-pressure with issue_valid poking during DONE.
        run_op(6'd10, 32'h110, 32'h0, 1'b0, 7'd8, 0, 1, 3, 1'b1);

        // Flush in WAIT, response two cycles later is discarded.
        next_cycle(); quiet(); set_issue(32'h300, 1'b0); issue_valid = 1'b1; #1;
        expect_ctl("fw.c0", 1'b1, 1'b0, 1'b0);
        next_cycle(); quiet(); dmem_bus.gnt = 1'b1; #1;
        expect_ctl("fw.c1", 1'b0, 1'b1, 1'b0);
        next_cycle(); quiet(); flush = 1'b1; #1;
        expect_ctl("fw.c2", 1'b0, 1'b0, 1'b0);
        next_cycle(); quiet(); #1;
        expect_ctl("fw.c3", 1'b0, 1'b0, 1'b0);
        next_cycle(); quiet(); dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'hBAD0_BAD0; #1;
        expect_ctl("fw.c4", 1'b0, 1'b0, 1'b0);
        next_cycle(); quiet(); #1;
        expect_ctl("fw.c5", 1'b1, 1'b0, 1'b0);
        run_op(6'd11, 32'h304, 32'h0, 1'b0, 7'd9, 0, 0, 0, 1'b0);

        // Flush in REQ before gnt drops the request.
        next_cycle(); quiet(); set_issue(32'h308, 1'b0); issue_valid = 1'b1; #1;
        next_cycle(); quiet(); flush = 1'b1; #1;
        check("fr.avail", 32'(mem_available), 32'h0);
        check("fr.cdbv", 32'(cdb_valid), 32'h0);
        next_cycle(); quiet(); #1;
        expect_ctl("fr.after", 1'b1, 1'b0, 1'b0);

        // Flush with gnt commits the store; DRAIN then times out.
        next_cycle(); quiet(); set_issue(32'h30C, 1'b1); issue_valid = 1'b1; #1;
        next_cycle(); quiet(); flush = 1'b1; dmem_bus.gnt = 1'b1; #1;
        check("fg.we", 32'(dmem_bus.we), 32'h1);
        for (int i = 0; i < TIMEOUT; i++) begin
            next_cycle(); quiet(); #1;
            expect_ctl("fg.drain", 1'b0, 1'b0, 1'b0);
        end
        next_cycle(); quiet(); #1;
        expect_ctl("fg.after", 1'b1, 1'b0, 1'b0);

        // Flush in IDLE suppresses accept; spurious rvalid in IDLE is ignored.
        next_cycle(); quiet(); set_issue(32'h310, 1'b0); issue_valid = 1'b1; flush = 1'b1;
        dmem_bus.rvalid = 1'b1; #1;
        check("fi.avail", 32'(mem_available), 32'h0);
        next_cycle(); quiet(); #1;
        expect_ctl("fi.after", 1'b1, 1'b0, 1'b0);

        // Flush in DONE: no broadcast.
        next_cycle(); quiet(); set_issue(32'h311, 1'b0); issue_valid = 1'b1; #1;
        next_cycle(); quiet(); flush = 1'b1; #1;
        expect_ctl("fd.c1", 1'b0, 1'b0, 1'b0);
        next_cycle(); quiet(); #1;
        expect_ctl("fd.c2", 1'b1, 1'b0, 1'b0);

        // Reset while holding a completion in DONE.
        next_cycle(); quiet(); set_issue(32'h313, 1'b0); issue_valid = 1'b1; #1;
        next_cycle(); quiet(); #1;
        check("rd.cdbv", 32'(cdb_valid), 32'h1);
        rst = 1'b1;
        next_cycle(); quiet(); rst = 1'b0; #1;
        expect_ctl("rd.after", 1'b1, 1'b0, 1'b0);
        check("rd.exc", 32'(cdb_exc), 32'h0);
        check("rd.prd", 32'(cdb_prd), 32'h0);
        check("rd.rob", 32'(cdb_rob_idx), 32'h0);

        // Randomized ops over a small address window so loads revisit stores.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_op(6'($urandom), a, $urandom, 1'($urandom), 7'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
